// File: rtl/child_dispatcher_if.sv
// Launch/join bus between the parent core, the dispatcher and the child fetch units.
interface child_dispatcher_if #(
  parameter int unsigned N_CHILD = 4,
  parameter int unsigned PC_W    = 32
);
  localparam int unsigned CORE_W = (N_CHILD > 1) ? $clog2(N_CHILD) : 1;

  logic                req_valid;
  logic                req_ready;
  logic [CORE_W-1:0]   req_core;
  logic [PC_W-1:0]     req_pc;
  logic [N_CHILD-1:0]  exec_requested;
  logic [PC_W-1:0]     requested_pc;
  logic [N_CHILD-1:0]  child_interlock;
  logic [N_CHILD-1:0]  child_done;
  logic [N_CHILD-1:0]  busy;
  logic                join_valid;
  logic [N_CHILD-1:0]  join_mask;
  logic                join_done;
  logic                err_spurious;

  // Parent core and children side
  modport master (
    output req_valid, req_core, req_pc, child_interlock, child_done, join_valid, join_mask,
    input  req_ready, exec_requested, requested_pc, busy, join_done, err_spurious
  );

  // Dispatcher side
  modport slave (
    input  req_valid, req_core, req_pc, child_interlock, child_done, join_valid, join_mask,
    output req_ready, exec_requested, requested_pc, busy, join_done, err_spurious
  );
endinterface

// File: rtl/child_dispatcher.sv
// Parent-side launcher: one outstanding launch on a shared PC bus, per-child
// IDLE/LAUNCH/RUN tracking, and a registered join barrier.
module child_dispatcher #(
  parameter int unsigned N_CHILD = 4,
  parameter int unsigned PC_W    = 32
) (
  input  logic               clk,
  input  logic               rstn,
  child_dispatcher_if.slave  bus
);
  localparam int unsigned CORE_W = (N_CHILD > 1) ? $clog2(N_CHILD) : 1;
  localparam int unsigned IDX_N  = 1 << CORE_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t              r_state [N_CHILD];
  logic [N_CHILD-1:0]  r_exec;
  logic [N_CHILD-1:0]  r_busy;
  logic [PC_W-1:0]     r_pc;
  logic                r_pending;
  logic                r_join_done;
  logic                r_err;

  logic [N_CHILD-1:0]  w_idle;
  logic [IDX_N-1:0]    w_idle_pad;
  logic [IDX_N-1:0]    w_mask_pad;
  logic [CORE_W-1:0]   w_core;
  logic                w_core_ok;
  logic                w_ready;
  logic                w_accept;
  logic                w_join;

  // Per-child idle flags for the readiness lookup
  always_comb begin
    w_idle = '0;
    for (int i = 0; i < N_CHILD; i++) begin
      w_idle[i] = (r_state[i] == ST_IDLE);
    end
  end

  // A single child has no index to decode
  assign w_core     = (N_CHILD == 1) ? '0 : bus.req_core;
  assign w_core_ok  = (N_CHILD == 1) || ({1'b0, w_core} < (CORE_W+1)'(N_CHILD));
  assign w_idle_pad = IDX_N'(w_idle);
  assign w_mask_pad = IDX_N'(bus.join_mask);

  assign w_ready  = ~r_pending & w_core_ok & w_idle_pad[w_core];
  assign w_accept = bus.req_valid & w_ready;

  // Barrier is clear when no masked child is busy, pending, or being launched right now
  assign w_join = bus.join_valid
                & ~|(r_busy & bus.join_mask)
                & ~|(r_exec & bus.join_mask)
                & ~(w_accept & w_mask_pad[w_core]);

  // Launch bus, per-child state machines, barrier and error flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_CHILD; i++) begin
        r_state[i] <= ST_IDLE;
      end
      r_exec      <= '0;
      r_busy      <= '0;
      r_pc        <= '0;
      r_pending   <= 1'b0;
      r_join_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pc      <= bus.req_pc;
        r_pending <= 1'b1;
      end
      for (int i = 0; i < N_CHILD; i++) begin
        case (r_state[i])
          ST_IDLE: begin
            if (w_accept && (w_core == CORE_W'(i))) begin
              r_state[i] <= ST_LAUNCH;
              r_exec[i]  <= 1'b1;
              r_busy[i]  <= 1'b1;
            end
            if (bus.child_done[i]) begin
              r_err <= 1'b1;
            end
          end
          ST_LAUNCH: begin
            // Child latches requested_pc on this edge; the bus is free next cycle
            if (r_exec[i] && bus.child_interlock[i]) begin
              r_state[i] <= ST_RUN;
              r_exec[i]  <= 1'b0;
              r_pending  <= 1'b0;
            end
            if (bus.child_done[i]) begin
              r_err <= 1'b1;
            end
          end
          ST_RUN: begin
            if (bus.child_done[i]) begin
              r_state[i] <= ST_IDLE;
              r_busy[i]  <= 1'b0;
            end
          end
          default: begin
            r_state[i] <= ST_IDLE;
            r_exec[i]  <= 1'b0;
            r_busy[i]  <= 1'b0;
          end
        endcase
      end
      r_join_done <= w_join;
    end
  end

  assign bus.req_ready      = w_ready;
  assign bus.exec_requested = r_exec;
  assign bus.requested_pc   = r_pc;
  assign bus.busy           = r_busy;
  assign bus.join_done      = r_join_done;
  assign bus.err_spurious   = r_err;
endmodule

// File: tb/tb_child_dispatcher.sv
// Directed bench for child_dispatcher: launch handshake, interlock wait,
// busy blocking, join barrier, spurious-done flag and async reset.
module tb_child_dispatcher;
  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  child_dispatcher_if #(.N_CHILD(4), .PC_W(32)) bus ();

  child_dispatcher #(.N_CHILD(4), .PC_W(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a child with interlock already high: accept edge then handshake edge
  task automatic launch(input logic [1:0] core, input logic [31:0] pc);
    bus.req_valid = 1'b1;
    bus.req_core  = core;
    bus.req_pc    = pc;
    tick();
    bus.req_valid = 1'b0;
    tick();
  endtask

  // One-cycle child_done pulse
  task automatic pulse_done(input logic [3:0] bits);
    bus.child_done = bits;
    tick();
    bus.child_done = 4'b0000;
  endtask

  task automatic test_reset();
    rstn                = 1'b0;
    bus.req_valid       = 1'b0;
    bus.req_core        = 2'd0;
    bus.req_pc          = 32'h0;
    bus.child_interlock = 4'b0000;
    bus.child_done      = 4'b0000;
    bus.join_valid      = 1'b0;
    bus.join_mask       = 4'b0000;
    #1;
    n_checks++;
    if (bus.exec_requested !== 4'b0000) begin n_errors++; $display("FAIL reset_exec got %b want 0000", bus.exec_requested); end
    n_checks++;
    if (bus.busy !== 4'b0000) begin n_errors++; $display("FAIL reset_busy got %b want 0000", bus.busy); end
    n_checks++;
    if (bus.requested_pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc got %h want 0", bus.requested_pc); end
    n_checks++;
    if (bus.join_done !== 1'b0 || bus.err_spurious !== 1'b0) begin
      n_errors++; $display("FAIL reset_flags got jd=%b err=%b want 0 0", bus.join_done, bus.err_spurious);
    end
    n_checks++;
    if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_launch_basic();
    bus.child_interlock = 4'b1111;
    bus.req_valid       = 1'b1;
    bus.req_core        = 2'd2;
    bus.req_pc          = 32'h100;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL basic_ready0 got %b want 1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    bus.req_core  = 2'd0;
    #1;
    n_checks++;
    if (bus.exec_requested !== 4'b0100) begin n_errors++; $display("FAIL basic_exec got %b want 0100", bus.exec_requested); end
    n_checks++;
    if (bus.requested_pc !== 32'h100) begin n_errors++; $display("FAIL basic_pc got %h want 100", bus.requested_pc); end
    n_checks++;
    if (bus.busy !== 4'b0100) begin n_errors++; $display("FAIL basic_busy got %b want 0100", bus.busy); end
    n_checks++;
    if (bus.req_ready !== 1'b0) begin n_errors++; $display("FAIL basic_ready_pending got %b want 0", bus.req_ready); end
    tick();
    n_checks++;
    if (bus.exec_requested !== 4'b0000) begin n_errors++; $display("FAIL basic_exec_drop got %b want 0000", bus.exec_requested); end
    n_checks++;
    if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL basic_ready_after got %b want 1", bus.req_ready); end
    n_checks++;
    if (bus.requested_pc !== 32'h100 || bus.busy !== 4'b0100) begin
      n_errors++; $display("FAIL basic_hold got pc=%h busy=%b want 100 0100", bus.requested_pc, bus.busy);
    end
    pulse_done(4'b0100);
    #1;
    n_checks++;
    if (bus.busy !== 4'b0000) begin n_errors++; $display("FAIL basic_done_busy got %b want 0000", bus.busy); end
  endtask

  task automatic test_interlock_wait();
    bus.child_interlock = 4'b1101;
    bus.req_valid       = 1'b1;
    bus.req_core        = 2'd1;
    bus.req_pc          = 32'h200;
    tick();
    bus.req_valid = 1'b0;
    bus.req_core  = 2'd3;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (bus.exec_requested !== 4'b0010 || bus.req_ready !== 1'b0) begin
        n_errors++; $display("FAIL wait_cycle%0d got exec=%b rdy=%b want 0010 0", k, bus.exec_requested, bus.req_ready);
      end
      tick();
    end
    bus.child_interlock = 4'b1111;
    #1;
    n_checks++;
    if (bus.exec_requested !== 4'b0010 || bus.req_ready !== 1'b0) begin
      n_errors++; $display("FAIL wait_cycle5 got exec=%b rdy=%b want 0010 0", bus.exec_requested, bus.req_ready);
    end
    tick();
    n_checks++;
    if (bus.exec_requested !== 4'b0000 || bus.req_ready !== 1'b1 || bus.busy !== 4'b0010) begin
      n_errors++; $display("FAIL wait_handshake got exec=%b rdy=%b busy=%b want 0000 1 0010",
                           bus.exec_requested, bus.req_ready, bus.busy);
    end
    pulse_done(4'b0010);
  endtask

  task automatic test_join();
    bus.child_interlock = 4'b1111;
    launch(2'd0, 32'h300);
    launch(2'd3, 32'h340);
    n_checks++;
    if (bus.busy !== 4'b1001) begin n_errors++; $display("FAIL join_setup_busy got %b want 1001", bus.busy); end
    bus.join_valid = 1'b1;
    bus.join_mask  = 4'b0000;
    tick();
    n_checks++;
    if (bus.join_done !== 1'b1) begin n_errors++; $display("FAIL join_empty_mask got %b want 1", bus.join_done); end
    bus.join_mask = 4'b1001;
    tick();
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (bus.join_done !== 1'b0) begin n_errors++; $display("FAIL join_wait_a%0d got %b want 0", k, bus.join_done); end
      tick();
    end
    pulse_done(4'b0001);
    #1;
    n_checks++;
    if (bus.join_done !== 1'b0 || bus.busy !== 4'b1000) begin
      n_errors++; $display("FAIL join_half got jd=%b busy=%b want 0 1000", bus.join_done, bus.busy);
    end
    for (int k = 0; k < 9; k++) begin
      tick();
      n_checks++;
      if (bus.join_done !== 1'b0) begin n_errors++; $display("FAIL join_wait_b%0d got %b want 0", k, bus.join_done); end
    end
    pulse_done(4'b1000);
    #1;
    n_checks++;
    if (bus.join_done !== 1'b0) begin n_errors++; $display("FAIL join_latency got %b want 0", bus.join_done); end
    tick();
    n_checks++;
    if (bus.join_done !== 1'b1) begin n_errors++; $display("FAIL join_set got %b want 1", bus.join_done); end
    bus.join_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.join_done !== 1'b0) begin n_errors++; $display("FAIL join_release got %b want 0", bus.join_done); end

    // Accept for a masked child in the same cycle as the barrier request
    bus.join_valid = 1'b1;
    bus.join_mask  = 4'b0100;
    bus.req_valid  = 1'b1;
    bus.req_core   = 2'd2;
    bus.req_pc     = 32'h400;
    tick();
    bus.req_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.join_done !== 1'b0 || bus.busy !== 4'b0100) begin
      n_errors++; $display("FAIL join_race got jd=%b busy=%b want 0 0100", bus.join_done, bus.busy);
    end
    tick();
    n_checks++;
    if (bus.join_done !== 1'b0) begin n_errors++; $display("FAIL join_race_run got %b want 0", bus.join_done); end
    pulse_done(4'b0100);
    #1;
    n_checks++;
    if (bus.join_done !== 1'b0) begin n_errors++; $display("FAIL join_race_done0 got %b want 0", bus.join_done); end
    tick();
    n_checks++;
    if (bus.join_done !== 1'b1) begin n_errors++; $display("FAIL join_race_done1 got %b want 1", bus.join_done); end
    bus.join_valid = 1'b0;
    bus.join_mask  = 4'b0000;
    tick();
  endtask

  task automatic test_busy_block();
    bus.child_interlock = 4'b1111;
    launch(2'd0, 32'h500);
    bus.req_valid = 1'b1;
    bus.req_core  = 2'd0;
    bus.req_pc    = 32'h510;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0) begin n_errors++; $display("FAIL block_ready got %b want 0", bus.req_ready); end
    tick();
    n_checks++;
    if (bus.exec_requested !== 4'b0000) begin n_errors++; $display("FAIL block_exec got %b want 0000", bus.exec_requested); end
    bus.child_done = 4'b0001;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0) begin n_errors++; $display("FAIL block_ready_done got %b want 0", bus.req_ready); end
    tick();
    bus.child_done = 4'b0000;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL block_ready_after got %b want 1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.exec_requested !== 4'b0001 || bus.requested_pc !== 32'h510) begin
      n_errors++; $display("FAIL block_relaunch got exec=%b pc=%h want 0001 510", bus.exec_requested, bus.requested_pc);
    end
    tick();
    pulse_done(4'b0001);
    tick();
  endtask

  task automatic test_spurious();
    n_checks++;
    if (bus.err_spurious !== 1'b0) begin n_errors++; $display("FAIL spur_before got %b want 0", bus.err_spurious); end
    pulse_done(4'b0100);
    #1;
    n_checks++;
    if (bus.err_spurious !== 1'b1 || bus.busy !== 4'b0000) begin
      n_errors++; $display("FAIL spur_set got err=%b busy=%b want 1 0000", bus.err_spurious, bus.busy);
    end
    tick();
    tick();
    n_checks++;
    if (bus.err_spurious !== 1'b1) begin n_errors++; $display("FAIL spur_sticky got %b want 1", bus.err_spurious); end
  endtask

  task automatic test_reset_mid_launch();
    bus.child_interlock = 4'b1101;
    bus.req_valid       = 1'b1;
    bus.req_core        = 2'd1;
    bus.req_pc          = 32'h600;
    tick();
    bus.req_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.exec_requested !== 4'b0010) begin n_errors++; $display("FAIL rst_pre_exec got %b want 0010", bus.exec_requested); end
    rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.exec_requested !== 4'b0000 || bus.busy !== 4'b0000) begin
      n_errors++; $display("FAIL rst_async got exec=%b busy=%b want 0000 0000", bus.exec_requested, bus.busy);
    end
    n_checks++;
    if (bus.requested_pc !== 32'h0 || bus.err_spurious !== 1'b0) begin
      n_errors++; $display("FAIL rst_async_regs got pc=%h err=%b want 0 0", bus.requested_pc, bus.err_spurious);
    end
    tick();
    rstn = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready got %b want 1", bus.req_ready); end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_launch_basic();
    test_interlock_wait();
    test_join();
    test_busy_block();
    test_spurious();
    test_reset_mid_launch();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
